// File: rtl/axil_fifo_regbank.sv
// AXI4-Lite slave exposing a word FIFO through a four-register map (DATA, STATUS, CTRL, THRESH)
// with sticky overflow/underflow flags and a count-threshold level interrupt.
module axil_fifo_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf, unf, irq_en;
  logic [15:0]   thresh;

  logic       wr_fire, rd_fire, full, empty;
  logic       push, pop, push_ok, pop_ok;
  logic       ctrl_wr, thresh_wr, flush, clr;
  logic [1:0] waddr, raddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic       rd_err;
  logic       unused_bits;

  assign unused_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0], s00_axi_wstrb[3:2]};

  assign waddr   = s00_axi_awaddr[3:2];
  assign raddr   = s00_axi_araddr[3:2];
  assign wr_fire = !s00_axi_areset & s00_axi_awvalid & s00_axi_wvalid & !s00_axi_bvalid;
  assign rd_fire = !s00_axi_areset & s00_axi_arvalid & !s00_axi_rvalid;

  assign s00_axi_awready = wr_fire;
  assign s00_axi_wready  = wr_fire;
  assign s00_axi_arready = rd_fire;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = wr_fire & (waddr == 2'd0);
  assign pop   = rd_fire & (raddr == 2'd0);
  // A pop frees a slot in the same cycle, so a push onto a full FIFO still lands.
  assign pop_ok  = pop & !empty;
  assign push_ok = push & (!full | pop_ok);

  assign ctrl_wr   = wr_fire & (waddr == 2'd2);
  assign thresh_wr = wr_fire & (waddr == 2'd3);
  assign flush     = ctrl_wr & s00_axi_wstrb[0] & s00_axi_wdata[0];
  assign clr       = ctrl_wr & s00_axi_wstrb[0] & s00_axi_wdata[2];

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (raddr)
      2'd0: begin
        if (empty) rd_err = 1'b1;
        else       rd_word = mem[rptr];
      end
      2'd1:    rd_word = {16'(count), 12'b0, unf, ovf, full, empty};
      2'd2:    rd_word = {29'b0, 1'b0, irq_en, 1'b0};
      default: rd_word = {16'b0, thresh};
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (push_ok) mem[wptr] <= s00_axi_wdata;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      irq_en <= 1'b0;
      thresh <= '0;
      irq    <= 1'b0;
    end else begin
      // Flush may coincide with a pop; the pop already captured the old head.
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop_ok)  rptr <= rptr + 1'b1;
        count <= count + CW'(push_ok) - CW'(pop_ok);
      end
      // A fresh error event wins over a clear issued in the same cycle.
      if (clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (push & !push_ok) ovf <= 1'b1;
      if (pop & empty)     unf <= 1'b1;
      if (ctrl_wr & s00_axi_wstrb[0]) irq_en <= s00_axi_wdata[1];
      if (thresh_wr & s00_axi_wstrb[0]) thresh[7:0]  <= s00_axi_wdata[7:0];
      if (thresh_wr & s00_axi_wstrb[1]) thresh[15:8] <= s00_axi_wdata[15:8];
      irq <= irq_en & (thresh != 16'd0) & (32'(count) >= 32'(thresh));
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= OKAY;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rresp  <= OKAY;
      s00_axi_rdata  <= '0;
    end else begin
      if (s00_axi_bvalid & s00_axi_bready) s00_axi_bvalid <= 1'b0;
      if (wr_fire) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= (push & !push_ok) ? SLVERR : OKAY;
      end
      if (s00_axi_rvalid & s00_axi_rready) s00_axi_rvalid <= 1'b0;
      if (rd_fire) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_word;
        s00_axi_rresp  <= rd_err ? SLVERR : OKAY;
      end
    end
  end
endmodule

// File: tb/tb_axil_fifo_regbank.sv
// Bench for axil_fifo_regbank: queue-based reference model checked every cycle,
// directed register-map scenarios with literal expectations, then random traffic.
module tb_axil_fifo_regbank;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_fifo_regbank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(D)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned q[$];
  bit          m_ovf, m_unf, m_irqen, started;
  logic [15:0] m_th;
  bit          e_bv, e_rv, e_irq;
  logic [1:0]  e_br, e_rr;
  logic [31:0] e_rd;

  always @(posedge clk) begin : mdl
    int n;
    bit wr, rd, popd, unf_set, flsh, irq_nxt;
    logic [31:0] st;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_irqen = 0; m_th = '0;
      e_bv = 0; e_rv = 0; e_irq = 0; e_br = 2'b00; e_rr = 2'b00; e_rd = '0;
      started = 1;
    end else begin
      n       = q.size();
      wr      = awvalid && wvalid && !e_bv;
      rd      = arvalid && !e_rv;
      popd    = 0;
      unf_set = 0;
      flsh    = 0;
      irq_nxt = m_irqen && (m_th != 0) && (n >= int'(m_th));
      st = (32'(n) << 16) | (32'(m_unf) << 3) | (32'(m_ovf) << 2)
         | (32'(n == D) << 1) | 32'(n == 0);
      if (e_bv && bready) e_bv = 0;
      if (e_rv && rready) e_rv = 0;
      if (rd) begin
        e_rv = 1; e_rr = 2'b00;
        case (araddr[3:2])
          2'd0: if (n == 0) begin e_rd = 0; e_rr = 2'b10; unf_set = 1; end
                else begin e_rd = q.pop_front(); popd = 1; end
          2'd1: e_rd = st;
          2'd2: e_rd = 32'(m_irqen) * 2;
          default: e_rd = 32'(m_th);
        endcase
      end
      if (wr) begin
        e_bv = 1; e_br = 2'b00;
        case (awaddr[3:2])
          2'd0: if (n < D || popd) q.push_back(wdata);
                else begin m_ovf = 1; e_br = 2'b10; end
          2'd2: if (wstrb[0]) begin
                  m_irqen = wdata[1];
                  if (wdata[2]) begin m_ovf = 0; m_unf = 0; end
                  flsh = wdata[0];
                end
          2'd3: begin
                  if (wstrb[0]) m_th[7:0]  = wdata[7:0];
                  if (wstrb[1]) m_th[15:8] = wdata[15:8];
                end
          default: ;
        endcase
      end
      if (flsh) q.delete();
      if (unf_set) m_unf = 1;
      e_irq = irq_nxt;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("awready", 32'(awready), 32'(awvalid && wvalid && !e_bv && !rst));
      chk("wready",  32'(wready),  32'(awvalid && wvalid && !e_bv && !rst));
      chk("arready", 32'(arready), 32'(arvalid && !e_rv && !rst));
      chk("bvalid",  32'(bvalid),  32'(e_bv));
      if (e_bv) chk("bresp", 32'(bresp), 32'(e_br));
      chk("rvalid",  32'(rvalid),  32'(e_rv));
      if (e_rv) begin
        chk("rdata", rdata, e_rd);
        chk("rresp", 32'(rresp), 32'(e_rr));
      end
      chk("irq", 32'(irq), 32'(e_irq));
    end
  end

  // ---------------- driver ----------------
  task automatic wr_txn(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int bdly, output logic [1:0] resp);
    int k;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!awready && k < 20);
    if (!awready) begin errors++; checks++; $display("FAIL wr_handshake timeout t=%0t", $time); end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    repeat (bdly) @(posedge clk);
    #1 bready = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bvalid && k < 20);
    if (!bvalid) begin errors++; checks++; $display("FAIL bvalid timeout t=%0t", $time); end
    resp = bresp;
    @(posedge clk); #1 bready = 0;
  endtask

  task automatic rd_txn(input logic [3:0] a, input int rdly,
                        output logic [31:0] d, output logic [1:0] resp);
    int k;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!arready && k < 20);
    if (!arready) begin errors++; checks++; $display("FAIL rd_handshake timeout t=%0t", $time); end
    @(posedge clk); #1;
    arvalid = 0;
    repeat (rdly) @(posedge clk);
    #1 rready = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!rvalid && k < 20);
    if (!rvalid) begin errors++; checks++; $display("FAIL rvalid timeout t=%0t", $time); end
    d = rdata; resp = rresp;
    @(posedge clk); #1 rready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r, r2;
    logic [31:0] d;
    logic [31:0] vec [4];
    vec[0] = 32'h0101FFFF; vec[1] = 32'hABCD0001; vec[2] = 32'hDEAD0011; vec[3] = 32'hBEEF0011;
    rst = 1; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0;
    bready = 0; arvalid = 0; rready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    rd_txn(4'h4, 0, d, r); chk("reset_status", d, 32'h1);
    rd_txn(4'hC, 0, d, r); chk("reset_thresh", d, 32'h0);

    // ordered push/pop
    for (int i = 0; i < 4; i++) begin wr_txn(4'h0, vec[i], 4'hF, 0, r); chk("push_resp", 32'(r), 0); end
    for (int i = 0; i < 4; i++) begin
      rd_txn(4'h0, 0, d, r); chk("pop_data", d, vec[i]); chk("pop_resp", 32'(r), 0);
    end
    rd_txn(4'h4, 0, d, r); chk("status_after_drain", d, 32'h1);

    // overflow / underflow / sticky clear
    for (int i = 0; i < D; i++) begin wr_txn(4'h0, 32'h100 + i, 4'h0, 0, r); chk("fill_resp", 32'(r), 0); end
    wr_txn(4'h0, 32'hDEADDEAD, 4'hF, 0, r); chk("overflow_resp", 32'(r), 2);
    rd_txn(4'h4, 0, d, r); chk("status_full_ovf", d, 32'h00100006);
    for (int i = 0; i < D; i++) begin rd_txn(4'h0, 0, d, r); chk("drain_data", d, 32'h100 + i); end
    rd_txn(4'h0, 0, d, r); chk("underflow_data", d, 0); chk("underflow_resp", 32'(r), 2);
    rd_txn(4'h4, 0, d, r); chk("status_stickies", d, 32'hD);
    wr_txn(4'h8, 32'h4, 4'h1, 0, r);
    rd_txn(4'h4, 0, d, r); chk("status_cleared", d, 32'h1);

    // simultaneous push and pop while full
    for (int i = 0; i < D; i++) wr_txn(4'h0, 32'h200 + i, 4'hF, 0, r);
    fork
      wr_txn(4'h0, 32'hAAAA5555, 4'hF, 0, r);
      rd_txn(4'h0, 0, d, r2);
    join
    chk("full_pp_wresp", 32'(r), 0); chk("full_pp_rresp", 32'(r2), 0); chk("full_pp_data", d, 32'h200);
    rd_txn(4'h4, 0, d, r); chk("full_pp_status", d, 32'h00100002);
    wr_txn(4'h8, 32'h1, 4'h1, 0, r);

    // threshold interrupt
    wr_txn(4'hC, 32'h4, 4'hF, 0, r);
    wr_txn(4'h8, 32'h2, 4'h1, 0, r);
    for (int i = 0; i < 3; i++) wr_txn(4'h0, 32'h300 + i, 4'hF, 0, r);
    @(negedge clk); chk("irq_below", 32'(irq), 0);
    wr_txn(4'h0, 32'h303, 4'hF, 0, r);
    @(negedge clk); chk("irq_at_thresh", 32'(irq), 1);
    rd_txn(4'h0, 0, d, r);
    @(negedge clk); chk("irq_after_pop", 32'(irq), 0);

    // flush
    wr_txn(4'h8, 32'h1, 4'h1, 0, r);
    for (int i = 0; i < 3; i++) wr_txn(4'h0, 32'h400 + i, 4'hF, 0, r);
    wr_txn(4'h8, 32'h1, 4'h1, 0, r);
    rd_txn(4'h4, 0, d, r); chk("status_flushed", d, 32'h1);
    wr_txn(4'h0, 32'h55, 4'hF, 0, r);
    rd_txn(4'h0, 0, d, r); chk("post_flush_pop", d, 32'h55);

    // reset drops a pending write response
    @(posedge clk); #1;
    awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    @(negedge clk); chk("bvalid_pending", 32'(bvalid), 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk); chk("bvalid_after_reset", 32'(bvalid), 0);
    rd_txn(4'h4, 0, d, r); chk("status_after_reset", d, 32'h1);

    // random traffic, checked cycle by cycle against the model
    for (int it = 0; it < 400; it++) begin
      int op;
      logic [31:0] rd_d;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: wr_txn(4'h0, $urandom, 4'($urandom), $urandom_range(0, 2), r);
        4, 5, 6:    rd_txn(4'h0, $urandom_range(0, 2), rd_d, r);
        7: fork
             wr_txn(4'h0, $urandom, 4'hF, $urandom_range(0, 2), r);
             rd_txn(4'h0, $urandom_range(0, 2), rd_d, r2);
           join
        8: if ($urandom_range(0, 1) == 1)
             wr_txn(4'h8, ($urandom & 32'hFFFF_FFF6) | 32'($urandom_range(0, 7) == 0), 4'($urandom),
                    $urandom_range(0, 2), r);
           else
             wr_txn(4'hC, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 20)), 4'($urandom),
                    $urandom_range(0, 2), r);
        default: rd_txn(4'($urandom_range(0, 3) * 4), $urandom_range(0, 2), rd_d, r);
      endcase
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
